// File: rtl/sata_phyinit_multi_pkg.sv
// Shared definitions for the SATA PHY bring-up sequencer: state encodings,
// synchroniser depth and fixed short-wait length.
package sata_phy_pkg;

  typedef enum logic [3:0] {
    ST_POWER_DOWN   = 4'd0,
    ST_PLL_RESET    = 4'd1,
    ST_PLL_WAIT     = 4'd2,
    ST_GTX_RESET    = 4'd3,
    ST_USER_READY   = 4'd4,
    ST_GTX_WAIT     = 4'd5,
    ST_CDRLOCK_WAIT = 4'd6,
    ST_ALIGN_WAIT   = 4'd7,
    ST_READY        = 4'd8,
    ST_FAILED       = 4'd9
  } state_t;

  localparam int SYNC_DEPTH = 5;
  localparam int SHORT_WAIT = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sata_phyinit_multi_sync.sv
// Multi-flop synchroniser for asynchronous status inputs, with a synchronous
// clear that forces every stage low.
module sata_sync_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/sata_phyinit_multi.sv
// Multi-lane GTX bring-up sequencer: shared PLL reset, common GTX reset,
// per-lane done/alignment qualification, watchdog with bounded retries.
module sata_phyinit_multi
  import sata_phy_pkg::*;
#(
  parameter int   NLANES            = 1,
  parameter logic OPT_WAIT_ON_ALIGN = 1'b0,
  parameter int   POWERDOWN_CYCLES  = 100,
  parameter int   GTX_RESET_CYCLES  = 50,
  parameter int   CDR_WAIT_LOG2     = 11,
  parameter int   WDOG_LOG2         = 20,
  parameter int   MAX_RETRIES       = 3
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_power_down,
  input  logic [NLANES-1:0]                  i_lane_en,
  output logic                               o_pll_reset,
  input  logic                               i_pll_locked,
  output logic                               o_gtx_reset,
  input  logic [NLANES-1:0]                  i_gtx_reset_done,
  input  logic [NLANES-1:0]                  i_aligned,
  output logic                               o_user_ready,
  output logic                               o_complete,
  output logic                               o_err,
  output logic                               o_fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   o_retries,
  output logic [3:0]                         o_state
);

  localparam int CDR_CYCLES = 2**CDR_WAIT_LOG2;
  localparam int CMAX = max_int(max_int(POWERDOWN_CYCLES, GTX_RESET_CYCLES),
                                max_int(CDR_CYCLES, SHORT_WAIT));
  localparam int CW = $clog2(CMAX + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  state_t            state, state_next;
  logic [CW-1:0]     count, load;
  logic              zero;
  logic [WDOG_LOG2:0] wdog;
  logic              wdog_on, timeout, pll_lost, err_next;
  logic [RW-1:0]     retries_next;
  logic              restart;
  logic              pll_locked, lanes_done, lanes_aligned;
  logic [NLANES-1:0] done_sync, align_sync;

  assign restart = i_reset | i_power_down;

  sata_sync_pipe #(.WIDTH(1), .DEPTH(SYNC_DEPTH)) u_sync_pll (
    .clk(i_clk), .clear(restart | o_pll_reset), .d(i_pll_locked), .q(pll_locked)
  );

  sata_sync_pipe #(.WIDTH(NLANES), .DEPTH(SYNC_DEPTH)) u_sync_done (
    .clk(i_clk), .clear(restart | o_pll_reset | o_gtx_reset),
    .d(i_gtx_reset_done), .q(done_sync)
  );

  sata_sync_pipe #(.WIDTH(NLANES), .DEPTH(SYNC_DEPTH)) u_sync_align (
    .clk(i_clk), .clear(restart | o_gtx_reset), .d(i_aligned), .q(align_sync)
  );

  // Disabled lanes count as done/aligned, so an empty mask never blocks.
  assign lanes_done    = &(done_sync | ~i_lane_en);
  assign lanes_aligned = OPT_WAIT_ON_ALIGN ? &(align_sync | ~i_lane_en) : 1'b1;

  assign wdog_on  = state inside {ST_USER_READY, ST_GTX_WAIT, ST_CDRLOCK_WAIT, ST_ALIGN_WAIT};
  assign timeout  = wdog_on & wdog[WDOG_LOG2];
  assign pll_lost = ~pll_locked & (state inside {ST_GTX_RESET, ST_USER_READY, ST_GTX_WAIT,
                                                 ST_CDRLOCK_WAIT, ST_ALIGN_WAIT, ST_READY});
  assign o_state  = state;

  always_comb begin
    state_next   = state;
    err_next     = 1'b0;
    retries_next = o_retries;
    case (state)
      ST_POWER_DOWN:   if (zero) state_next = ST_PLL_RESET;
      ST_PLL_RESET:    if (zero) state_next = ST_PLL_WAIT;
      ST_PLL_WAIT:     if (zero && pll_locked) state_next = ST_GTX_RESET;
      ST_GTX_RESET:    if (zero) state_next = ST_USER_READY;
      ST_USER_READY:   if (zero) state_next = ST_GTX_WAIT;
      ST_GTX_WAIT:     if (zero && lanes_done) state_next = ST_CDRLOCK_WAIT;
      ST_CDRLOCK_WAIT: if (zero) state_next = OPT_WAIT_ON_ALIGN ? ST_ALIGN_WAIT : ST_READY;
      ST_ALIGN_WAIT:   if (lanes_aligned) state_next = ST_READY;
      ST_READY:        if (OPT_WAIT_ON_ALIGN && !lanes_aligned) state_next = ST_ALIGN_WAIT;
      ST_FAILED:       state_next = ST_FAILED;
      default:         state_next = ST_PLL_RESET;
    endcase
    if (timeout) begin
      err_next = 1'b1;
      if (o_retries == RW'(MAX_RETRIES)) begin
        state_next = ST_FAILED;
      end else begin
        state_next   = ST_GTX_RESET;
        retries_next = o_retries + RW'(1);
      end
    end
    // PLL loss restarts from the top and is not counted as a retry.
    if (pll_lost) begin
      state_next   = ST_PLL_RESET;
      err_next     = 1'b0;
      retries_next = o_retries;
    end
    if (state_next == ST_READY && state != ST_READY) retries_next = '0;
  end

  always_comb begin
    load = '0;
    case (state_next)
      ST_POWER_DOWN:   load = CW'(POWERDOWN_CYCLES);
      ST_GTX_RESET:    load = CW'(GTX_RESET_CYCLES);
      ST_PLL_WAIT,
      ST_USER_READY,
      ST_GTX_WAIT:     load = CW'(SHORT_WAIT);
      ST_CDRLOCK_WAIT: load = CW'(CDR_CYCLES);
      default:         load = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (restart) begin
      state        <= ST_POWER_DOWN;
      count        <= CW'(POWERDOWN_CYCLES);
      zero         <= (POWERDOWN_CYCLES == 0);
      wdog         <= '0;
      o_pll_reset  <= 1'b1;
      o_gtx_reset  <= 1'b1;
      o_user_ready <= 1'b0;
      o_complete   <= 1'b0;
      o_err        <= 1'b0;
      o_fail       <= 1'b0;
      o_retries    <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        count <= load;
        zero  <= (load == '0);
      end else if (count != '0) begin
        count <= count - CW'(1);
        zero  <= (count == CW'(1));
      end
      if (!wdog_on || timeout) wdog <= '0;
      else                     wdog <= wdog + 1'b1;
      o_pll_reset  <= state_next inside {ST_POWER_DOWN, ST_PLL_RESET, ST_FAILED};
      o_gtx_reset  <= state_next inside {ST_POWER_DOWN, ST_PLL_RESET, ST_PLL_WAIT,
                                         ST_GTX_RESET, ST_FAILED};
      o_user_ready <= state_next inside {ST_GTX_WAIT, ST_CDRLOCK_WAIT, ST_ALIGN_WAIT, ST_READY};
      o_complete   <= (state_next == ST_READY);
      o_fail       <= (state_next == ST_FAILED);
      o_err        <= err_next;
      o_retries    <= retries_next;
    end
  end

endmodule

// File: tb/tb_sata_phyinit_multi.sv
// Scoreboard bench: two sequencer instances (no-align with 2 retries, align-wait
// with 3 retries); expected completion/error snapshots are queued by stimulus.
module tb_sata_phyinit_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] id;
    logic [3:0] st;
    logic [1:0] rt;
    logic       fl;
    logic       cp;
    logic       ur;
  } ev_t;

  ev_t q_a[$];
  ev_t q_b[$];

  logic       a_rst, a_pd, a_pll_locked;
  logic [1:0] a_lane_en, a_done, a_aligned;
  logic       a_pll_reset, a_gtx_reset, a_ur, a_cp, a_err, a_fail;
  logic [1:0] a_rt;
  logic [3:0] a_st;

  logic       b_rst, b_pd, b_pll_locked;
  logic [1:0] b_lane_en, b_done, b_aligned;
  logic       b_pll_reset, b_gtx_reset, b_ur, b_cp, b_err, b_fail;
  logic [1:0] b_rt;
  logic [3:0] b_st;

  sata_phyinit_multi #(
    .NLANES(2), .OPT_WAIT_ON_ALIGN(1'b0), .CDR_WAIT_LOG2(4), .WDOG_LOG2(8), .MAX_RETRIES(2)
  ) dut_a (
    .i_clk(clk), .i_reset(a_rst), .i_power_down(a_pd), .i_lane_en(a_lane_en),
    .o_pll_reset(a_pll_reset), .i_pll_locked(a_pll_locked), .o_gtx_reset(a_gtx_reset),
    .i_gtx_reset_done(a_done), .i_aligned(a_aligned), .o_user_ready(a_ur),
    .o_complete(a_cp), .o_err(a_err), .o_fail(a_fail), .o_retries(a_rt), .o_state(a_st)
  );

  sata_phyinit_multi #(
    .NLANES(2), .OPT_WAIT_ON_ALIGN(1'b1), .CDR_WAIT_LOG2(4), .WDOG_LOG2(8), .MAX_RETRIES(3)
  ) dut_b (
    .i_clk(clk), .i_reset(b_rst), .i_power_down(b_pd), .i_lane_en(b_lane_en),
    .o_pll_reset(b_pll_reset), .i_pll_locked(b_pll_locked), .o_gtx_reset(b_gtx_reset),
    .i_gtx_reset_done(b_done), .i_aligned(b_aligned), .o_user_ready(b_ur),
    .o_complete(b_cp), .o_err(b_err), .o_fail(b_fail), .o_retries(b_rt), .o_state(b_st)
  );

  function automatic ev_t ev(input int id, input int st, input int rt,
                             input bit fl, input bit cp, input bit ur);
    ev_t e;
    e.id = 8'(id); e.st = 4'(st); e.rt = 2'(rt); e.fl = fl; e.cp = cp; e.ur = ur;
    return e;
  endfunction

  function void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  function void ev_cmp(input string name, input ev_t exp, input ev_t act);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s id=%0d actual(st,rt,fl,cp,ur)=%0d,%0d,%0d,%0d,%0d required=%0d,%0d,%0d,%0d,%0d",
               name, exp.id, act.st, act.rt, act.fl, act.cp, act.ur,
               exp.st, exp.rt, exp.fl, exp.cp, exp.ur);
    end
  endfunction

  // Monitors: an o_err pulse or a rising o_complete is an output event.
  logic a_cp_prev = 1'b0, b_cp_prev = 1'b0;
  int   a_err_cnt = 0;
  ev_t  a_act, b_act;

  always @(negedge clk) begin
    if (a_err || (a_cp && !a_cp_prev)) begin
      if (a_err) a_err_cnt++;
      a_act = ev(0, int'(a_st), int'(a_rt), a_fail, a_cp, a_ur);
      if (q_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL ev_a unexpected actual st=%0d rt=%0d err=%0d required=none", a_st, a_rt, a_err);
      end else begin
        a_act.id = q_a[0].id;
        ev_cmp("ev_a", q_a.pop_front(), a_act);
      end
    end
    a_cp_prev = a_cp;
  end

  always @(negedge clk) begin
    if (b_err || (b_cp && !b_cp_prev)) begin
      b_act = ev(0, int'(b_st), int'(b_rt), b_fail, b_cp, b_ur);
      if (q_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL ev_b unexpected actual st=%0d rt=%0d err=%0d required=none", b_st, b_rt, b_err);
      end else begin
        b_act.id = q_b[0].id;
        ev_cmp("ev_b", q_b.pop_front(), b_act);
      end
    end
    b_cp_prev = b_cp;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input bit sel, input int s, input int budget, input string name);
    int n = 0;
    while (int'(sel ? b_st : a_st) != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(sel ? b_st : a_st), s);
  endtask

  task automatic wait_drained(input bit sel, input int budget, input string name);
    int n = 0;
    while ((sel ? q_b.size() : q_a.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, sel ? q_b.size() : q_a.size(), 0);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_state"}, a_st, 0);
    chk({tag, "_pll_reset"}, a_pll_reset, 1);
    chk({tag, "_gtx_reset"}, a_gtx_reset, 1);
    chk({tag, "_user_ready"}, a_ur, 0);
    chk({tag, "_complete"}, a_cp, 0);
    chk({tag, "_err"}, a_err, 0);
    chk({tag, "_fail"}, a_fail, 0);
    chk({tag, "_retries"}, a_rt, 0);
  endtask

  initial begin
    int pll_fall, gtx_fall, gtx_hi, err_base;
    bit saw;

    a_rst = 1'b1; a_pd = 1'b0; a_lane_en = 2'b11; a_pll_locked = 1'b1;
    a_done = 2'b11; a_aligned = 2'b11;
    b_rst = 1'b1; b_pd = 1'b0; b_lane_en = 2'b11; b_pll_locked = 1'b1;
    b_done = 2'b11; b_aligned = 2'b01;
    cyc(3);
    chk_reset_a("por");

    // Clean bring-up with every input high.
    q_a.push_back(ev(1, 8, 0, 0, 1, 1));
    a_rst = 1'b0;
    pll_fall = -1; gtx_fall = -1; gtx_hi = 0;
    for (int n = 0; n < 1000 && q_a.size() != 0; n++) begin
      @(negedge clk);
      if (pll_fall < 0 && !a_pll_reset) pll_fall = n;
      if (gtx_fall < 0 && !a_gtx_reset) gtx_fall = n;
      if (a_gtx_reset && !a_pll_reset) gtx_hi++;
    end
    chk("complete_1_seen", q_a.size(), 0);
    chk("pll_before_gtx", int'(pll_fall >= 0 && pll_fall < gtx_fall), 1);
    chk("gtx_hi_ge_50", int'(gtx_hi >= 50), 1);

    // Reset while stalled in GTX_WAIT.
    a_done = 2'b01; a_rst = 1'b1; cyc(1); a_rst = 1'b0;
    wait_state(0, 5, 400, "stall_gtx_wait");
    cyc(3);
    a_rst = 1'b1; cyc(1);
    chk_reset_a("rst_in_gtx_wait");

    // Lane 1 never done: one timeout, then mask it off.
    q_a.push_back(ev(2, 3, 1, 0, 0, 0));
    a_rst = 1'b0;
    wait_drained(0, 1500, "err_1_seen");
    a_lane_en = 2'b01;
    q_a.push_back(ev(3, 8, 0, 0, 1, 1));
    wait_drained(0, 1500, "complete_after_mask");
    chk("retries_cleared", a_rt, 0);

    // PLL lock loss in READY.
    a_pll_locked = 1'b0; saw = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (a_pll_reset && !saw) begin
        saw = 1'b1;
        chk("pll_loss_complete", a_cp, 0);
        chk("pll_loss_retries", a_rt, 0);
        chk("pll_loss_state", a_st, 1);
      end
    end
    chk("pll_reset_reassert", saw, 1);
    q_a.push_back(ev(4, 8, 0, 0, 1, 1));
    a_pll_locked = 1'b1;
    wait_drained(0, 500, "recomplete");

    // Retries exhausted: three timeouts then FAILED.
    a_rst = 1'b1; a_lane_en = 2'b11; a_done = 2'b01; cyc(1); a_rst = 1'b0;
    err_base = a_err_cnt;
    q_a.push_back(ev(5, 3, 1, 0, 0, 0));
    q_a.push_back(ev(6, 3, 2, 0, 0, 0));
    q_a.push_back(ev(7, 9, 2, 1, 0, 0));
    wait_drained(0, 3000, "three_errs");
    cyc(300);
    chk("err_count", a_err_cnt - err_base, 3);
    chk("fail_state", a_st, 9);
    chk("fail_flag", a_fail, 1);
    chk("fail_pll_reset", a_pll_reset, 1);
    a_pd = 1'b1; cyc(1); a_pd = 1'b0;
    chk("pd_clears_fail", a_fail, 0);
    chk("pd_state", a_st, 0);

    // Alignment gating on the second instance.
    b_rst = 1'b0;
    wait_state(1, 7, 600, "align_wait_entry");
    cyc(20);
    chk("align_hold_state", b_st, 7);
    chk("align_hold_complete", b_cp, 0);
    q_b.push_back(ev(8, 8, 0, 0, 1, 1));
    b_aligned = 2'b11;
    wait_drained(1, 100, "aligned_complete");
    b_aligned = 2'b10;
    wait_state(1, 7, 50, "align_loss_state");
    cyc(1);
    chk("align_loss_complete", b_cp, 0);
    chk("align_loss_user_ready", b_ur, 1);

    cyc(5);
    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
